regfile_wb_arbiter: RTL and testbench

- Controls the single register-file write port (WE3/A3/WD3) of the 5-stage core.
- Arbitrates between two write sources:
  - the in-order WB stage;
  - a long-latency execution unit (mul/div), whose result is held in a 1-entry buffer.
- Keeps a 31-bit scoreboard of registers with pending long-latency writes and raises the decode hazard stall.
- Bounds ext starvation by back-pressuring WB after MAX_WAIT lost arbitrations.

---
 rtl/regfile_wb_arbiter.sv | 88 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the regfile write port between WB and a buffered long-latency result, with scoreboard stall.
// Define ARB_PERF_EN to add perf_wait_cycles/perf_forced counters.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
`ifdef ARB_PERF_EN
    output logic [31:0]     perf_wait_cycles,
    output logic [31:0]     perf_forced,
`endif
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_ready,
    input  logic            ext_valid,
    input  logic [4:0]      ext_rd,
    input  logic [XLEN-1:0] ext_data,
    output logic            ext_ready,
    input  logic            dec_valid,
    input  logic            dec_long,
    input  logic [4:0]      dec_rs1,
    input  logic [4:0]      dec_rs2,
    input  logic [4:0]      dec_rd,
    output logic            hazard_stall,
    output logic            rf_we,
    output logic [4:0]      rf_a3,
    output logic [XLEN-1:0] rf_wd
);
    localparam logic [3:0] MW = 4'(MAX_WAIT);
    logic            buf_valid;
    logic [4:0]      buf_rd;
    logic [XLEN-1:0] buf_data;
    logic [3:0]      wait_cnt;
    logic [31:1]     sb;
    logic [31:1]     sb_next;
    logic [31:0]     sb_full;
    logic            force_grant;
    logic            wb_win;
    logic            buf_grant;
    logic            sb_set_en;
    always_comb begin
        sb_full      = {sb, 1'b0};
        force_grant  = buf_valid && wait_cnt == MW;
        wb_win       = !force_grant && wb_valid && wb_rd != 5'd0;
        buf_grant    = buf_valid && !wb_win;
        wb_ready     = !rst && !force_grant;
        ext_ready    = !rst && (!buf_valid || buf_grant);
        hazard_stall = !rst && dec_valid && (sb_full[dec_rs1] || sb_full[dec_rs2] || sb_full[dec_rd]);
        rf_we        = !rst && (wb_win || (buf_grant && buf_rd != 5'd0));
        rf_a3        = wb_win ? wb_rd : buf_rd;
        rf_wd        = wb_win ? wb_data : buf_data;
        sb_set_en    = dec_valid && dec_long && !hazard_stall && dec_rd != 5'd0;
        // set is applied after clear so a coinciding set wins
        for (int i = 1; i < 32; i++)
            sb_next[i] = (sb[i] && !(buf_grant && buf_rd == 5'(i))) || (sb_set_en && dec_rd == 5'(i));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            wait_cnt  <= 4'd0;
            sb        <= '0;
        end else begin
            if (ext_valid && ext_ready) begin
                buf_valid <= 1'b1;
                buf_rd    <= ext_rd;
                buf_data  <= ext_data;
            end else if (buf_grant) begin
                buf_valid <= 1'b0;
            end
            wait_cnt <= buf_grant ? 4'd0 :
                        (buf_valid && wb_win && wait_cnt != MW) ? wait_cnt + 4'd1 : wait_cnt;
            sb <= sb_next;
        end
    end
`ifdef ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_wait_cycles <= '0;
            perf_forced      <= '0;
        end else begin
            perf_wait_cycles <= perf_wait_cycles + 32'(buf_valid && !buf_grant);
            perf_forced      <= perf_forced + 32'(force_grant);
        end
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed plus random traffic, expectations queued from a reference model and checked by a monitor.
module tb_regfile_wb_arbiter;
    localparam int MAX_WAIT = 4;
    localparam int XLEN = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wb_valid = 1'b0, ext_valid = 1'b0, dec_valid = 1'b0, dec_long = 1'b0;
    logic [4:0] wb_rd = '0, ext_rd = '0, dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic [XLEN-1:0] wb_data = '0, ext_data = '0;
    logic wb_ready, ext_ready, hazard_stall, rf_we;
    logic [4:0] rf_a3;
    logic [XLEN-1:0] rf_wd;
`ifdef ARB_PERF_EN
    logic [31:0] perf_wait_cycles, perf_forced;
`endif

    regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
`ifdef ARB_PERF_EN
        .perf_wait_cycles(perf_wait_cycles), .perf_forced(perf_forced),
`endif
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .ext_valid(ext_valid), .ext_rd(ext_rd), .ext_data(ext_data), .ext_ready(ext_ready),
        .dec_valid(dec_valid), .dec_long(dec_long), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .hazard_stall(hazard_stall),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic we; logic [4:0] a3; logic [31:0] wd;
        logic wbr; logic exr; logic st;
        logic [31:0] pw; logic [31:0] pf;
    } exp_t;
    exp_t q[$];
    int checks = 0, failures = 0;

    // reference model: buffered result, lost-arbitration count, pending-register set
    bit m_bv;
    bit [4:0] m_brd;
    bit [31:0] m_bd;
    int m_lost;
    bit pend[32];
    int unsigned m_pw, m_pf;
    bit last_wbr = 1'b1, last_exr = 1'b1;
    bit [4:0] issued_q[$];

    task automatic model_reset();
        m_bv = 0; m_lost = 0; m_pw = 0; m_pf = 0;
        foreach (pend[i]) pend[i] = 0;
        issued_q.delete();
    endtask

    task automatic step(input bit r, input bit wv, input bit [4:0] wrd, input bit [31:0] wd,
                        input bit ev, input bit [4:0] erd, input bit [31:0] ed,
                        input bit dv, input bit dl, input bit [4:0] s1, input bit [4:0] s2, input bit [4:0] drd);
        exp_t e;
        bit frc, wbwin, bg;
        rst = r; wb_valid = wv; wb_rd = wrd; wb_data = wd;
        ext_valid = ev; ext_rd = erd; ext_data = ed;
        dec_valid = dv; dec_long = dl; dec_rs1 = s1; dec_rs2 = s2; dec_rd = drd;
        e.pw = m_pw; e.pf = m_pf;
        if (r) begin
            e.we = 0; e.a3 = 0; e.wd = 0; e.wbr = 0; e.exr = 0; e.st = 0;
            model_reset();
        end else begin
            frc   = m_bv && m_lost == MAX_WAIT;
            wbwin = !frc && wv && wrd != 0;
            bg    = m_bv && !wbwin;
            e.wbr = !frc;
            e.exr = !m_bv || bg;
            e.st  = dv && (pend[s1] || pend[s2] || pend[drd]);
            e.we  = wbwin || (bg && m_brd != 0);
            e.a3  = wbwin ? wrd : m_brd;
            e.wd  = wbwin ? wd : m_bd;
            if (m_bv && !bg) m_pw++;
            if (frc) m_pf++;
            if (wbwin && m_bv && m_lost < MAX_WAIT) m_lost++;
            if (bg) begin pend[m_brd] = 0; m_lost = 0; m_bv = 0; end
            if (dv && dl && !e.st && drd != 0) begin pend[drd] = 1; issued_q.push_back(drd); end
            if (ev && e.exr) begin m_bv = 1; m_brd = erd; m_bd = ed; end
        end
        last_wbr = e.wbr; last_exr = e.exr;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit dv = 0, input bit [4:0] s1 = 0, input bit [4:0] drd = 0);
        step(0, 0, 0, 0, 0, 0, 0, dv, 0, s1, 0, drd);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", n, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("wb_ready", 32'(wb_ready), 32'(e.wbr));
            chk("ext_ready", 32'(ext_ready), 32'(e.exr));
            chk("hazard_stall", 32'(hazard_stall), 32'(e.st));
            chk("rf_we", 32'(rf_we), 32'(e.we));
            if (e.we) begin
                chk("rf_a3", 32'(rf_a3), 32'(e.a3));
                chk("rf_wd", rf_wd, e.wd);
            end
`ifdef ARB_PERF_EN
            chk("perf_wait_cycles", perf_wait_cycles, e.pw);
            chk("perf_forced", perf_forced, e.pf);
`endif
        end
    end

    initial begin
        bit hwv, hev, r, dv, dl;
        bit [4:0] hwrd, herd, s1, s2, drd, rd;
        bit [31:0] hwd, hed;
        model_reset();
        @(posedge clk); #1;
        // reset then idle, single WB write
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        step(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
        // long op to x7, RAW stall until its result is written
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 7);
        step(0, 0, 0, 0, 1, 7, 32'hAA, 1, 0, 7, 0, 8);
        idle(1, 7, 8);
        idle(1, 7, 8);
        // starvation bound: buffer full while WB keeps writing
        step(0, 0, 0, 0, 1, 10, 32'h77, 0, 0, 0, 0, 0);
        rd = 1;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, rd, 32'h100 + 32'(rd), 0, 0, 0, 0, 0, 0, 0, 0);
            if (last_wbr) rd++;
        end
        // WB rd=0 lets the buffer drain while a new result refills it
        step(0, 1, 1, 32'h11, 1, 3, 32'h55, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h99, 1, 4, 32'h66, 0, 0, 0, 0, 0);
        idle();
        // WAW on a pending register
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 9);
        idle(1, 0, 9);
        step(0, 0, 0, 0, 1, 9, 32'h999, 1, 0, 0, 0, 9);
        idle(1, 0, 9);
        idle(1, 0, 9);
        // reset with a full buffer and a pending register
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 12);
        step(0, 1, 2, 32'h22, 1, 13, 32'hD, 0, 0, 0, 0, 0);
        step(0, 1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 12, 12);
        idle();
        // random traffic honouring the hold rules of both producers
        hwv = 0; hev = 0; hwrd = 0; herd = 0; hwd = 0; hed = 0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(199) == 0);
            if (!(hwv && !last_wbr)) begin
                hwv = ($urandom_range(9) < 7);
                hwrd = 5'($urandom_range(31));
                hwd = $urandom;
            end
            if (!(hev && !last_exr)) begin
                hev = 0;
                if (issued_q.size() > 0 && $urandom_range(2) == 0) begin
                    hev = 1; herd = issued_q.pop_front(); hed = $urandom;
                end else if ($urandom_range(15) == 0) begin
                    hev = 1; herd = 5'($urandom_range(31)); hed = $urandom;
                end
            end
            dv = $urandom_range(3) != 0;
            dl = $urandom_range(4) == 0;
            s1 = 5'($urandom_range(15));
            s2 = 5'($urandom_range(15));
            drd = 5'($urandom_range(15));
            step(r, hwv, hwrd, hwd, hev, herd, hed, dv, dl, s1, s2, drd);
        end
        idle();
        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
